// File: rtl/hdmi_vid_pkg.sv
// Shared video constants, pattern/state enums, colour-bar table and CRC helper
// for the hdmi_vtg_pattern timing generator.
package hdmi_vid_pkg;

    localparam int CNT_W = 12;

    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_BLACK = 2'd3
    } pat_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } vtg_state_e;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
    } ycc_t;

    localparam logic [7:0] Y_WHITE = 8'd235;
    localparam logic [7:0] Y_BLACK = 8'd16;
    localparam logic [7:0] C_MID   = 8'd128;

    localparam ycc_t BLACK_YCC = '{y: Y_BLACK, cb: C_MID, cr: C_MID};

    // White, yellow, cyan, green, magenta, red, blue, black (left to right).
    localparam ycc_t BAR_TABLE [0:7] = '{
        '{y: 8'd235, cb: 8'd128, cr: 8'd128},
        '{y: 8'd210, cb: 8'd16,  cr: 8'd146},
        '{y: 8'd170, cb: 8'd166, cr: 8'd16},
        '{y: 8'd145, cb: 8'd54,  cr: 8'd34},
        '{y: 8'd106, cb: 8'd202, cr: 8'd222},
        '{y: 8'd81,  cb: 8'd90,  cr: 8'd240},
        '{y: 8'd41,  cb: 8'd240, cr: 8'd110},
        '{y: 8'd16,  cb: 8'd128, cr: 8'd128}
    };

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // CRC-16-CCITT over one 16-bit word, MSB first.
    function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [15:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ CRC_POLY;
        end
        return c;
    endfunction

endpackage

// File: rtl/hdmi_vtg_pattern_if.sv
// Control inputs and video outputs of hdmi_vtg_pattern; master = video source,
// slave = video consumer / controller.
interface hdmi_vtg_pattern_if;

    logic        en;
    logic [1:0]  pattern_sel;
    logic        pix_ce;
    logic        hdmi_hsync;
    logic        hdmi_vsync;
    logic        hdmi_de;
    logic [15:0] hdmi_d;
    logic        sof;
    logic [15:0] frame_cnt;
    logic [15:0] frame_crc;

    modport master (
        input  en, pattern_sel,
        output pix_ce, hdmi_hsync, hdmi_vsync, hdmi_de, hdmi_d,
        output sof, frame_cnt, frame_crc
    );

    modport slave (
        output en, pattern_sel,
        input  pix_ce, hdmi_hsync, hdmi_vsync, hdmi_de, hdmi_d,
        input  sof, frame_cnt, frame_crc
    );

endinterface

// File: rtl/vid_pattern_gen.sv
// Combinational test-pattern lookup: (x, y, pattern, odd) -> {Y, Cb|Cr}.
module vid_pattern_gen
    import hdmi_vid_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE
) (
    input  logic [CNT_W-1:0] i_x,
    input  logic [CNT_W-1:0] i_y,
    input  pat_e             i_sel,
    input  logic             i_odd,
    output logic [15:0]      o_pix
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] w_bar_idx;
    ycc_t       w_ycc;
    logic       w_unused_y;

    assign w_unused_y = ^{i_y[CNT_W-1:6], i_y[4:0]};

    // Threshold compare avoids a divider when the bar width is not a power of two.
    always_comb begin
        w_bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (i_x >= CNT_W'(i * BAR_W)) w_bar_idx = 3'(i);
        end
    end

    always_comb begin
        w_ycc = BLACK_YCC;
        case (i_sel)
            PAT_BARS:  w_ycc = BAR_TABLE[w_bar_idx];
            PAT_RAMP:  w_ycc = '{y: i_x[7:0], cb: C_MID, cr: C_MID};
            PAT_CHECK: w_ycc = '{y: (i_x[5] ^ i_y[5]) ? Y_WHITE : Y_BLACK, cb: C_MID, cr: C_MID};
            default:   w_ycc = BLACK_YCC;
        endcase
    end

    assign o_pix = {w_ycc.y, i_odd ? w_ycc.cr : w_ycc.cb};

endmodule

// File: rtl/hdmi_vtg_pattern.sv
// Video timing generator + YCbCr 4:2:2 test-pattern source for the ADV7511.
// Optional per-frame CRC of active pixels is enabled by defining FRAME_CRC_EN.
module hdmi_vtg_pattern
    import hdmi_vid_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic              clk_100,
    input  logic              reset,
    hdmi_vtg_pattern_if.master vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PS_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [PS_W-1:0]  r_presc;
    logic             r_pix_ce;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    vtg_state_e       r_state;
    vtg_state_e       w_state_nxt;
    pat_e             r_sel;
    pat_e             w_sel;
    logic             r_hs;
    logic             r_vs;
    logic             r_de;
    logic [15:0]      r_d;
    logic             r_sof;
    logic [15:0]      r_frame_cnt;

    logic             w_tick;
    logic             w_emit;
    logic             w_h_last;
    logic             w_v_last;
    logic             w_frame_pos;
    logic             w_active;
    logic             w_hs_on;
    logic             w_vs_on;
    logic [15:0]      w_pix;

    assign w_tick      = (r_presc == PS_LAST);
    assign w_h_last    = (r_h == H_LAST);
    assign w_v_last    = (r_v == V_LAST);
    assign w_frame_pos = (r_h == '0) && (r_v == '0);
    assign w_active    = (r_h < H_ACT) && (r_v < V_ACT);
    assign w_hs_on     = (r_h >= HS_BEG) && (r_h < HS_END);
    assign w_vs_on     = (r_v >= VS_BEG) && (r_v < VS_END);
    assign w_sel       = w_frame_pos ? pat_e'(vid.pattern_sel) : r_sel;

    // NOTE: pix_ce is registered so it reads 0 during reset even with CLK_DIV=1.
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            r_presc  <= '0;
            r_pix_ce <= 1'b0;
        end else begin
            r_presc  <= w_tick ? '0 : r_presc + 1'b1;
            r_pix_ce <= w_tick;
        end
    end

    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_emit = vid.en;
                if (w_tick && vid.en) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_emit = 1'b1;
                if (w_tick && !vid.en)
                    w_state_nxt = (w_h_last && w_v_last) ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: begin
                w_emit = 1'b1;
                if (w_tick) begin
                    if (vid.en)                      w_state_nxt = ST_RUN;
                    else if (w_h_last && w_v_last)   w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Counters sit at (0,0) in IDLE because DRAIN only exits on the frame wrap.
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            r_h   <= '0;
            r_v   <= '0;
            r_sel <= PAT_BARS;
        end else if (w_tick && w_emit) begin
            r_sel <= w_sel;
            if (w_h_last) begin
                r_h <= '0;
                r_v <= w_v_last ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    vid_pattern_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern (
        .i_x   (r_h),
        .i_y   (r_v),
        .i_sel (w_sel),
        .i_odd (r_h[0]),
        .o_pix (w_pix)
    );

    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            r_hs        <= ~HS_POL;
            r_vs        <= ~VS_POL;
            r_de        <= 1'b0;
            r_d         <= '0;
            r_sof       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_sof <= w_tick && w_emit && w_frame_pos;
            if (w_tick) begin
                if (w_emit) begin
                    r_hs <= w_hs_on ? HS_POL : ~HS_POL;
                    r_vs <= w_vs_on ? VS_POL : ~VS_POL;
                    r_de <= w_active;
                    r_d  <= w_active ? w_pix : '0;
                    if (w_frame_pos) r_frame_cnt <= r_frame_cnt + 16'd1;
                end else begin
                    r_hs <= ~HS_POL;
                    r_vs <= ~VS_POL;
                    r_de <= 1'b0;
                    r_d  <= '0;
                end
            end
        end
    end

`ifdef FRAME_CRC_EN
    logic [15:0] r_crc_acc;
    logic [15:0] r_frame_crc;
    logic        r_crc_valid;
    logic [15:0] w_pix_act;

    assign w_pix_act = w_active ? w_pix : '0;

    // Pixel (0,0) opens the new frame, so it seeds the fresh accumulator.
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            r_crc_acc   <= CRC_INIT;
            r_frame_crc <= '0;
            r_crc_valid <= 1'b0;
        end else if (w_tick && w_emit) begin
            if (w_frame_pos) begin
                if (r_crc_valid) r_frame_crc <= r_crc_acc;
                r_crc_valid <= 1'b1;
                r_crc_acc   <= w_active ? crc16_upd(CRC_INIT, w_pix_act) : CRC_INIT;
            end else if (w_active) begin
                r_crc_acc <= crc16_upd(r_crc_acc, w_pix_act);
            end
        end
    end

    assign vid.frame_crc = r_frame_crc;
`else
    assign vid.frame_crc = '0;
`endif

    assign vid.pix_ce     = r_pix_ce;
    assign vid.hdmi_hsync = r_hs;
    assign vid.hdmi_vsync = r_vs;
    assign vid.hdmi_de    = r_de;
    assign vid.hdmi_d     = r_d;
    assign vid.sof        = r_sof;
    assign vid.frame_cnt  = r_frame_cnt;

endmodule
